// File: rtl/protocheck3_axil_pkg.sv
// Shared definitions for the protocheck3 AXI4-Lite register slice:
// response codes, write-response state and register-index sizing.
package protocheck3_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    B_IDLE,
    B_RESP
  } b_state_e;

  function automatic int unsigned reg_idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/protocheck3_axil_wr_join.sv
// Write-channel join: independent one-entry AW and W holding registers,
// a single commit once both are full, and the B response state.
module protocheck3_axil_wr_join
  import protocheck3_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_en,
  output logic [IDX_WIDTH-1:0]  wr_idx,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb
);

  logic                 aw_full_q, aw_full_d;
  logic [IDX_WIDTH-1:0] aw_idx_q,  aw_idx_d;
  logic                 aw_err_q,  aw_err_d;
  logic                 w_full_q,  w_full_d;
  logic [31:0]          w_data_q,  w_data_d;
  logic [3:0]           w_strb_q,  w_strb_d;
  logic [1:0]           bresp_q,   bresp_d;
  b_state_e             b_state_q, b_state_d;

  logic unused_addr;
  assign unused_addr = ^awaddr[1:0];

  assign bvalid  = (b_state_q == B_RESP);
  assign bresp   = bresp_q;
  assign awready = en && !aw_full_q && !bvalid;
  assign wready  = en && !w_full_q  && !bvalid;
  assign wr_idx  = aw_idx_q;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    b_state_d = b_state_q;
    wr_en     = 1'b0;

    if (awvalid && awready) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[IDX_WIDTH+1:2];
      aw_err_d  = (awaddr >> (IDX_WIDTH + 2)) != '0;
    end
    if (wvalid && wready) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    case (b_state_q)
      B_IDLE: begin
        if (aw_full_q && w_full_q) begin
          wr_en     = !aw_err_q;
          bresp_d   = aw_err_q ? RESP_SLVERR : RESP_OKAY;
          b_state_d = B_RESP;
        end
      end
      B_RESP: begin
        // Entries stay full until the handshake so READY cannot rise in the same cycle.
        if (bready) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          b_state_d = B_IDLE;
        end
      end
      default: b_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      b_state_q <= B_IDLE;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      b_state_q <= b_state_d;
    end
  end

endmodule

// File: rtl/protocheck3_axil_regs.sv
// AXI4-Lite register bank: C_NUM_REGS 32-bit registers with byte strobes,
// SLVERR on out-of-range addresses, and a flat image of all registers.
module protocheck3_axil_regs
  import protocheck3_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS         = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [32*C_NUM_REGS-1:0]      REG_OUT
);

  localparam int unsigned IW = reg_idx_width(C_NUM_REGS);

  logic        en_q, en_d;
  logic [31:0] regs_q [C_NUM_REGS];
  logic [31:0] regs_d [C_NUM_REGS];
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [1:0]  rresp_q,  rresp_d;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [IW-1:0] rd_idx;
  logic          rd_err;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  protocheck3_axil_wr_join #(
    .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .IDX_WIDTH  (IW)
  ) u_wr_join (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .en      (en_q),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign S_AXI_ARREADY = en_q && !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign rd_idx        = S_AXI_ARADDR[IW+1:2];
  assign rd_err        = (S_AXI_ARADDR >> (IW + 2)) != '0;

  always_comb begin
    en_d     = 1'b1;
    regs_d   = regs_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end

    // Read samples regs_q, so a same-cycle commit to that register returns the old value.
    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : regs_q[rd_idx];
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    REG_OUT = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      REG_OUT[32*i +: 32] = regs_q[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      en_q     <= en_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_protocheck3_axil_regs.sv
// Randomized and directed checks of protocheck3_axil_regs against a simple
// array model of the register file and AXI-Lite response rules.
module tb_protocheck3_axil_regs;

  localparam int LIMIT = 50;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0]  rdata;
  logic [127:0] reg_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  protocheck3_axil_regs #(
    .C_S_AXI_ADDR_WIDTH (5),
    .C_S_AXI_DATA_WIDTH (32),
    .C_NUM_REGS         (4)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .REG_OUT       (reg_out)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input int addr);
    return (addr >= 16) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input bit skip_w);
    int t;
    logic [1:0] er;
    fork
      begin
        repeat (aw_dly) tick();
        awaddr = addr[4:0]; awprot = 3'($urandom); awvalid = 1'b1;
        t = 0;
        while (!awready && t < LIMIT) begin tick(); t++; end
        if (t >= LIMIT) check_eq("aw_timeout", 0, 1);
        tick();
        awvalid = 1'b0;
      end
      begin
        if (!skip_w) begin
          repeat (w_dly) tick();
          wdata = data; wstrb = strb; wvalid = 1'b1;
          while (!wready) tick();
          tick();
          wvalid = 1'b0;
        end
      end
    join
    t = 0;
    while (!bvalid && t < LIMIT) begin tick(); t++; end
    if (t >= LIMIT) check_eq("b_timeout", 0, 1);
    er = exp_resp(addr);
    check_eq("bresp", bresp, er);
    if (er == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[(addr / 4) % 4][8*b +: 8] = data[8*b +: 8];
    end
    for (int i = 0; i < b_dly; i++) begin
      check_eq("b_hold_valid", bvalid, 1);
      check_eq("b_hold_resp", bresp, er);
      check_eq("b_hold_awready", awready, 0);
      check_eq("b_hold_wready", wready, 0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("b_drop", bvalid, 0);
    check_eq("awready_after_b", awready, 1);
    check_eq("reg_out", reg_out, model_flat());
  endtask

  task automatic do_read(input int addr, input int r_dly);
    int t;
    logic [31:0] ed;
    logic [1:0]  er;
    er = exp_resp(addr);
    ed = (er == 2'b00) ? model[(addr / 4) % 4] : 32'h0;
    araddr = addr[4:0]; arprot = 3'($urandom); arvalid = 1'b1;
    t = 0;
    while (!arready && t < LIMIT) begin tick(); t++; end
    if (t >= LIMIT) check_eq("ar_timeout", 0, 1);
    tick();
    arvalid = 1'b0;
    check_eq("rvalid_latency", rvalid, 1);
    check_eq("rdata", rdata, ed);
    check_eq("rresp", rresp, er);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check_eq("r_hold_valid", rvalid, 1);
      check_eq("r_hold_data", rdata, ed);
      check_eq("r_hold_arready", arready, 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("r_drop", rvalid, 0);
  endtask

  initial begin
    int t;
    logic [127:0] snap;
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) tick();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_reg_out", reg_out, 0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", {awready, wready, arready}, 3'b111);

    // Basic write/readback of all registers
    for (int i = 0; i < 4; i++) do_write(4 * i, i + 1, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(4 * i, 0);
    check_eq("reg_out_1234", reg_out, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    while (!wready) tick();
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("w_first_wready", wready, 0);
      check_eq("w_first_bvalid", bvalid, 0);
      tick();
    end
    do_write(4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
    do_read(4, 0);

    // Byte strobes
    do_write(8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    do_write(8, 32'h12345678, 4'b0101, 1, 0, 0, 0);
    check_eq("strobe_model", model[2], 32'hFF34FF78);
    do_read(8, 0);

    // Out-of-range address
    snap = reg_out;
    do_write(16, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0);
    check_eq("slverr_no_change", reg_out, snap);
    do_read(16, 0);

    // Back-pressure on B and R
    do_write(12, 32'h0BADF00D, 4'hF, 0, 2, 10, 0);
    do_read(12, 10);

    // Read and commit to the same register in the same cycle
    fork
      do_write(0, 32'h55AA55AA, 4'hF, 0, 0, 0, 0);
      begin tick(); do_read(0, 0); end
    join
    do_read(0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, 31), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else
        do_read($urandom_range(0, 31), $urandom_range(0, 3));
    end

    // Reset while a response is pending
    awaddr = 5'd4; awvalid = 1'b1; wdata = 32'h13579BDF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < LIMIT) begin tick(); t++; end
    if (t >= LIMIT) check_eq("rst_b_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_bvalid_drop", bvalid, 0);
    check_eq("rst_ready_low", {awready, wready, arready}, 3'b000);
    check_eq("rst_clear_reg_out", reg_out, 0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst2", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 4; i++) do_read(4 * i, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/protocheck3_axil_regs.md
PROTOCHECK3_AXIL_REGS -- requirements
Module: protocheck3_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter C_NUM_REGS, default 4, number of 32-bit registers; power of two, 2..4.
REQ-004 SHALL have one clock and asynchronous active-low reset: ACLK in 1 clock; ARESETN in 1 asynchronous active-low reset.
REQ-005 SHALL have S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH write address.
REQ-006 SHALL have S_AXI_AWPROT in 3, accepted and ignored.
REQ-007 SHALL have S_AXI_AWVALID in 1 and S_AXI_AWREADY out 1 (AW handshake).
REQ-008 SHALL have S_AXI_WDATA in 32 write data; S_AXI_WSTRB in 4 byte strobes.
REQ-009 SHALL have S_AXI_WVALID in 1 and S_AXI_WREADY out 1 (W handshake).
REQ-010 SHALL have S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1 (write response).
REQ-011 SHALL have S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3, ignored.
REQ-012 SHALL have S_AXI_ARVALID in 1 and S_AXI_ARREADY out 1 (AR handshake).
REQ-013 SHALL have S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-014 SHALL have REG_OUT out 32*C_NUM_REGS, flat image of all registers, reg0 in LSBs.

Function
REQ-015 SHALL decode the register index from address bits [log2(C_NUM_REGS)+1:2]; bits [1:0] are ignored.
REQ-016 SHALL return SLVERR (2'b10) for any access with address bits above the index field non-zero; OKAY (2'b00) otherwise.
REQ-017 SHALL accept AW and W independently, in either order; each is latched in a one-entry holding register and its READY is driven low while that entry is full.
REQ-018 SHALL perform the register write in the cycle after both holding entries are full, updating only bytes with WSTRB set; SLVERR writes modify nothing.
REQ-019 SHALL assert BVALID in the same cycle as the write commit and hold it with BRESP stable until BREADY; both holding entries are freed on the B handshake.
REQ-020 SHALL hold at most one outstanding write: AWREADY/WREADY stay low while BVALID is high.
REQ-021 SHALL drive ARREADY high when no read is pending; on AR handshake it SHALL present RDATA/RRESP with RVALID on the next cycle (1-cycle latency) and hold them until RREADY.
REQ-022 SHALL return RDATA 0 for SLVERR reads.
REQ-023 SHALL hold ARREADY low while RVALID is high (one outstanding read).
REQ-024 SHALL, when a write commit and a read capture target the same register in the same cycle, return the pre-write value (read captures old data).
REQ-025 SHALL allow B handshake and new AW/W capture in the same cycle only after the B handshake completes (no same-cycle reuse; READY rises the cycle after BREADY&&BVALID).
REQ-026 SHALL update REG_OUT in the cycle after a write commit.

Reset
REQ-027 SHALL, while ARESETN is low, clear all registers, holding entries and REG_OUT to 0 and drive AWREADY, WREADY, ARREADY, BVALID, RVALID low, BRESP/RRESP 2'b00, RDATA 0.
REQ-028 SHALL abandon any in-flight transaction on reset; AWREADY/WREADY/ARREADY rise in the first ACLK edge after ARESETN deasserts.

Structure
REQ-029 SHALL take RESP_OKAY, RESP_SLVERR and the register-index width function from shared package protocheck3_axil_pkg.
REQ-030 SHALL implement the write channel join (AW/W holding entries plus B state) as sub-module protocheck3_axil_wr_join; the read path stays in the top.

Verification
REQ-031 SHALL test: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC then read back -> data 0x1..0x4, RRESP OKAY, REG_OUT=0x00000004_00000003_00000002_00000001.
REQ-032 SHALL test: W presented 3 cycles before AW at 0x4, data 0xDEADBEEF -> WREADY low after W capture, single BVALID after AW, reg1=0xDEADBEEF.
REQ-033 SHALL test: reg2=0xFFFFFFFF, write 0x12345678 with WSTRB=4'b0101 -> reg2 reads 0xFF34FF78.
REQ-034 SHALL test: write/read address 0x10 -> BRESP/RRESP 2'b10, RDATA 0, no register changes.
REQ-035 SHALL test: BREADY held low 10 cycles -> BVALID/BRESP stable, AWREADY/WREADY low throughout; RREADY held low likewise for reads.
REQ-036 SHALL test: ARESETN pulsed low while BVALID high -> BVALID drops immediately, all registers read 0 afterwards.
